// File: rtl/opener_input_conditioner_if.sv
// Raw sensor inputs and conditioned Opener inputs, grouped for the input conditioner.
interface opener_input_conditioner_if;
    logic b_raw;
    logic c_raw;
    logic o_raw;
    logic s_raw;
    logic b;
    logic c;
    logic o;
    logic s;
    logic fault;

    modport master (
        output b_raw, c_raw, o_raw, s_raw,
        input  b, c, o, s, fault
    );

    modport slave (
        input  b_raw, c_raw, o_raw, s_raw,
        output b, c, o, s, fault
    );
endinterface

// File: rtl/opener_input_conditioner.sv
// Synchronizes and debounces the Opener's button, limit and safety inputs; the button becomes a press pulse.
// Optional macro SAFETY_STRETCH_EN adds a STRETCH_CYCLES hold-off on the falling edge of the safety level.
module opener_input_conditioner #(
    parameter int DB_CYCLES      = 4,
    parameter int STRETCH_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      r,
    opener_input_conditioner_if.slave io
);
    localparam int NCH  = 4;
    localparam int CH_B = 3;
    localparam int CH_C = 2;
    localparam int CH_O = 1;
    localparam int CH_S = 0;
    localparam int CW   = $clog2(DB_CYCLES + 1);

    if (DB_CYCLES < 1 || STRETCH_CYCLES < 1) begin : g_bad_param
        $error("opener_input_conditioner: DB_CYCLES and STRETCH_CYCLES must be >= 1");
    end

    logic [NCH-1:0]         raw_s;
    logic [NCH-1:0]         sync1_q, sync1_d;
    logic [NCH-1:0]         sync2_q, sync2_d;
    logic [NCH-1:0]         stable_q, stable_d;
    logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
    logic                   b_prev_q, b_prev_d;
    logic                   b_q, b_d;
    logic                   fault_q, fault_d;

    assign raw_s = {io.b_raw, io.c_raw, io.o_raw, io.s_raw};

    // Two-flop synchronizer feeding a per-channel run-length debounce.
    always_comb begin
        sync1_d  = raw_s;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = {(NCH*CW){1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = {CW{1'b0}};
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1'b1);
                end
            end else begin
                cnt_d[i] = {CW{1'b0}};
            end
        end
    end

    // Press pulse is one cycle behind the filtered rise and shares fault's view of the limits.
    always_comb begin
        fault_d  = stable_q[CH_C] & stable_q[CH_O];
        b_prev_d = stable_q[CH_B];
        b_d      = stable_q[CH_B] & ~b_prev_q & ~fault_d;
    end

    // Main state registers.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            sync1_q  <= {NCH{1'b0}};
            sync2_q  <= {NCH{1'b0}};
            stable_q <= {NCH{1'b0}};
            cnt_q    <= {(NCH*CW){1'b0}};
            b_prev_q <= 1'b0;
            b_q      <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            b_prev_q <= b_prev_d;
            b_q      <= b_d;
            fault_q  <= fault_d;
        end
    end

`ifdef SAFETY_STRETCH_EN
    localparam int SW = $clog2(STRETCH_CYCLES + 1);

    logic [SW-1:0] stretch_q, stretch_d;
    logic          s_q, s_d;

    // Hold counter reloads while the beam is broken and drains after it clears.
    always_comb begin
        stretch_d = stretch_q;
        s_d       = 1'b0;
        if (stable_d[CH_S]) begin
            stretch_d = SW'(STRETCH_CYCLES);
            s_d       = 1'b1;
        end else if (stretch_q != {SW{1'b0}}) begin
            stretch_d = stretch_q - SW'(1'b1);
            s_d       = 1'b1;
        end else begin
            stretch_d = {SW{1'b0}};
            s_d       = 1'b0;
        end
    end

    // Stretch state registers.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            stretch_q <= {SW{1'b0}};
            s_q       <= 1'b0;
        end else begin
            stretch_q <= stretch_d;
            s_q       <= s_d;
        end
    end

    assign io.s = s_q;
`else
    assign io.s = stable_q[CH_S];
`endif

    assign io.b     = b_q;
    assign io.c     = stable_q[CH_C];
    assign io.o     = stable_q[CH_O];
    assign io.fault = fault_q;
endmodule

// File: tb/tb_opener_input_conditioner.sv
// Self-checking bench for opener_input_conditioner: vector table, hand sequences, random vs. window model.
module tb_opener_input_conditioner;
    localparam int DB = 4;
    localparam int ST = 8;

    logic clk = 1'b0;
    logic r;
    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;
    int   steps_n = 0;

    opener_input_conditioner_if ifc ();

    opener_input_conditioner #(.DB_CYCLES(DB), .STRETCH_CYCLES(ST)) dut (
        .clk (clk),
        .r   (r),
        .io  (ifc)
    );

    always #5 clk = ~clk;

    // Reference model: a filtered level flips once the last DB synchronized samples all disagree with it.
    logic [3:0] hist [0:DB];
    logic [3:0] filt_m, newf;
    logic       b_rose_m, b_m, fault_m, s_m, fault_new, flip;
    int         edge_n, last_s_hi;

    task automatic model_reset();
        for (int i = 0; i <= DB; i++) hist[i] = 4'b0000;
        filt_m = 4'b0000; b_rose_m = 1'b0; b_m = 1'b0; fault_m = 1'b0; s_m = 1'b0;
        edge_n = 0; last_s_hi = -100000;
    endtask

    task automatic model_update();
        if (!r) begin
            model_reset();
        end else begin
            edge_n = edge_n + 1;
            newf = filt_m;
            for (int ch = 0; ch < 4; ch++) begin
                flip = 1'b1;
                for (int i = 1; i <= DB; i++) if (hist[i][ch] == filt_m[ch]) flip = 1'b0;
                if (flip) newf[ch] = ~filt_m[ch];
            end
            fault_new = filt_m[2] & filt_m[1];
            b_m       = b_rose_m & ~fault_new;
            b_rose_m  = newf[3] & ~filt_m[3];
            fault_m   = fault_new;
            if (filt_m[0]) last_s_hi = edge_n - 1;
`ifdef SAFETY_STRETCH_EN
            s_m = newf[0] || ((edge_n - last_s_hi) <= ST);
`else
            s_m = newf[0];
`endif
            filt_m = newf;
            for (int i = DB; i >= 1; i--) hist[i] = hist[i-1];
            hist[0] = {ifc.b_raw, ifc.c_raw, ifc.o_raw, ifc.s_raw};
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_update();
            @(negedge clk);
            steps_n++;
            if (ifc.b === 1'b1) pulses++;
            chk("model_b", ifc.b, b_m);
            chk("model_c", ifc.c, filt_m[2]);
            chk("model_o", ifc.o, filt_m[1]);
            chk("model_s", ifc.s, s_m);
            chk("model_fault", ifc.fault, fault_m);
        end
    endtask

    task automatic set_raw(input logic [3:0] v);
        {ifc.b_raw, ifc.c_raw, ifc.o_raw, ifc.s_raw} = v;
    endtask

    task automatic do_reset(input int n);
        r = 1'b0;
        model_reset();
        step(n);
        r = 1'b1;
    endtask

    typedef struct {
        logic       rv;
        logic [3:0] raw;
        int         n;
        logic       eb, ec, eo, es, ef;
    } vec_t;

    vec_t       tbl [11];
    logic [3:0] rnd;
    int         t0, first;

    initial begin
        tbl[0]  = '{1'b0, 4'b1111, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'b1111, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 4'b1111, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 4'b1101, 5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 4'b1101, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 4'b1101, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 4'b0101, 6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 4'b1101, 6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4'b1101, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 4'b1101, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        r = 1'b0;
        set_raw(4'b1111);
        model_reset();
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            r = tbl[i].rv;
            set_raw(tbl[i].raw);
            if (!tbl[i].rv) model_reset();
            step(tbl[i].n);
            chk($sformatf("vec%0d_b", i), ifc.b, tbl[i].eb);
            chk($sformatf("vec%0d_c", i), ifc.c, tbl[i].ec);
            chk($sformatf("vec%0d_o", i), ifc.o, tbl[i].eo);
            chk($sformatf("vec%0d_s", i), ifc.s, tbl[i].es);
            chk($sformatf("vec%0d_fault", i), ifc.fault, tbl[i].ef);
        end

        // Bouncing button then a steady press: one pulse, 7 edges after the final toggle.
        set_raw(4'b0000);
        do_reset(2);
        set_raw(4'b0100);
        step(8);
        for (int i = 0; i < 10; i++) begin
            set_raw({(i % 2 == 0) ? 1'b1 : 1'b0, 3'b100});
            step(1);
        end
        set_raw(4'b1100);
        pulses = 0; t0 = steps_n; first = -1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (ifc.b === 1'b1 && first < 0) first = steps_n - t0;
        end
        chk_int("bounce_pulse_count", pulses, 1);
        chk_int("bounce_pulse_edge", first, 7);

        // Short glitch while held, then a clean release and re-press.
        pulses = 0;
        set_raw(4'b0100); step(2);
        set_raw(4'b1100); step(20);
        chk_int("glitch_no_pulse", pulses, 0);
        set_raw(4'b0100); step(10);
        set_raw(4'b1100); step(20);
        chk_int("repress_pulse", pulses, 1);

        // Limit fault onset, suppressed press, fault clear, then a fresh press.
        set_raw(4'b0100); step(10);
        set_raw(4'b0110); step(6);
        chk("fault_not_yet", ifc.fault, 1'b0);
        step(1);
        chk("fault_onset", ifc.fault, 1'b1);
        pulses = 0;
        set_raw(4'b1110); step(20);
        chk("fault_held", ifc.fault, 1'b1);
        set_raw(4'b1010); step(7);
        chk("fault_cleared", ifc.fault, 1'b0);
        chk_int("fault_press_suppressed", pulses, 0);
        set_raw(4'b0010); step(10);
        set_raw(4'b1010); step(10);
        chk_int("post_fault_press", pulses, 1);

        // Reset while the closed-limit debounce count sits at 3 of 4.
        set_raw(4'b1110); step(5);
        r = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_o", ifc.o, 1'b0);
        chk("rst_mid_c", ifc.c, 1'b0);
        chk("rst_mid_b", ifc.b, 1'b0);
        chk("rst_mid_s", ifc.s, 1'b0);
        chk("rst_mid_fault", ifc.fault, 1'b0);
        step(2);
        r = 1'b1;
        step(5);
        chk("rst_relat_c_early", ifc.c, 1'b0);
        chk("rst_relat_o_early", ifc.o, 1'b0);
        step(1);
        chk("rst_relat_c", ifc.c, 1'b1);
        chk("rst_relat_o", ifc.o, 1'b1);

        // Safety level: plain follow, or stretched hold-off with restart.
        set_raw(4'b0001); step(10);
`ifdef SAFETY_STRETCH_EN
        set_raw(4'b0000); step(13);
        chk("stretch_hold", ifc.s, 1'b1);
        step(1);
        chk("stretch_drop", ifc.s, 1'b0);
        set_raw(4'b0001); step(10);
        set_raw(4'b0000); step(8);
        set_raw(4'b0001);
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("stretch_restart_high", ifc.s, 1'b1);
        end
        set_raw(4'b0000); step(13);
        chk("stretch_hold2", ifc.s, 1'b1);
        step(1);
        chk("stretch_drop2", ifc.s, 1'b0);
`else
        set_raw(4'b0000); step(5);
        chk("s_follow_hold", ifc.s, 1'b1);
        step(1);
        chk("s_follow_drop", ifc.s, 1'b0);
`endif

        // Random bouncy inputs with occasional resets, checked against the model every cycle.
        rnd = 4'b0000;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(1, 2));
            end
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 5) == 0) rnd[ch] = ~rnd[ch];
            end
            set_raw(rnd);
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
